anneal_scheduler: RTL and testbench

Sequencer for the 144-spin VRSPAD latch chain. It takes an annealing schedule from the host and gates the chain's `enable` for a programmed number of cycles per step. Between steps it ramps the SPAD bias code down, freezes the chain, snapshots `state` and hands each snapshot to the readout path over a valid/ready handshake. It also holds the `cuts` configuration stable for the whole run, so the chain never sees a mid-run Ising/Potts topology change.

---
 rtl/anneal_pkg.sv | 24 ++
 rtl/anneal_scheduler_step_timer.sv | 28 ++
 rtl/anneal_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_anneal_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anneal_pkg.sv
// rtl/anneal_pkg.sv - shared state codes, default widths and bias arithmetic for the anneal scheduler
package anneal_pkg;

    localparam int N_SPIN_DEF     = 144;
    localparam int CYC_W_DEF      = 16;
    localparam int STEP_W_DEF     = 8;
    localparam int BIAS_W_DEF     = 8;
    localparam int FREEZE_CYC_DEF = 2;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] S_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] S_RUN     = 3'd1;
    localparam logic [ST_W-1:0] S_FREEZE  = 3'd2;
    localparam logic [ST_W-1:0] S_CAPTURE = 3'd3;
    localparam logic [ST_W-1:0] S_HOLD    = 3'd4;
    localparam logic [ST_W-1:0] S_ADVANCE = 3'd5;

    // Bias ramp step: a - b clamped at zero so the DAC code never wraps.
    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : 0;
    endfunction

endpackage

// File: rtl/anneal_scheduler_step_timer.sv
// rtl/anneal_scheduler_step_timer.sv - loadable down-counter timing the RUN and FREEZE intervals
// Ports: clk, rst (sync, active-high), load/load_val (preset count), en (count down), zero (count == 0).
module step_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/anneal_scheduler.sv
// rtl/anneal_scheduler.sv - step sequencer for the VRSPAD latch chain: enable gating, bias ramp, snapshot readout
// Ports: clk, rst (sync, active-high); start/abort control; cfg_* run configuration (shadowed on start);
//        state_in from the chain; latch_enable/cuts/bias_code drive the chain;
//        res_data/res_step/res_last with res_valid/res_ready readout handshake; busy, done status.
module anneal_scheduler
    import anneal_pkg::*;
#(
    parameter int N_SPIN     = N_SPIN_DEF,
    parameter int CYC_W      = CYC_W_DEF,
    parameter int STEP_W     = STEP_W_DEF,
    parameter int BIAS_W     = BIAS_W_DEF,
    parameter int FREEZE_CYC = FREEZE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CYC_W-1:0]  cfg_step_cycles,
    input  logic [STEP_W-1:0] cfg_num_steps,
    input  logic [BIAS_W-1:0] cfg_bias_start,
    input  logic [BIAS_W-1:0] cfg_bias_delta,
    input  logic              cfg_trace,
    input  logic [N_SPIN:0]   cfg_cuts,
    input  logic [N_SPIN-1:0] state_in,
    output logic              latch_enable,
    output logic [N_SPIN:0]   cuts,
    output logic [BIAS_W-1:0] bias_code,
    output logic [N_SPIN-1:0] res_data,
    output logic [STEP_W-1:0] res_step,
    output logic              res_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [CYC_W-1:0] FREEZE_M1 = CYC_W'(FREEZE_CYC - 1);

    logic [ST_W-1:0]   state;
    logic [STEP_W-1:0] step;

    // Shadow configuration; zero counts are folded to 1 here, stored as (count - 1).
    logic [CYC_W-1:0]  sh_cyc_m1;
    logic [STEP_W-1:0] sh_last_step;
    logic [BIAS_W-1:0] sh_delta;
    logic              sh_trace;

    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_zero;
    logic [CYC_W-1:0]  tmr_val;

    logic              step_final;
    logic              step_emits;

    assign step_final   = (step == sh_last_step);
    assign step_emits   = sh_trace || step_final;
    assign latch_enable = (state == S_RUN);
    assign busy         = (state != S_IDLE);
    assign tmr_en       = (state == S_RUN) || (state == S_FREEZE);

    // Timer preset: each interval loads (length - 1) and ends on the cycle it reads zero.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = sh_cyc_m1;
        case (state)
            S_IDLE: begin
                if (start) begin
                    tmr_load = 1'b1;
                    tmr_val  = (cfg_step_cycles == '0) ? '0 : cfg_step_cycles - CYC_W'(1);
                end
            end
            S_RUN: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = FREEZE_M1;
                end
            end
            S_ADVANCE: begin
                if (!step_final) begin
                    tmr_load = 1'b1;
                    tmr_val  = sh_cyc_m1;
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    step_timer #(
        .W(CYC_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            state        <= S_IDLE;
            step         <= '0;
            sh_cyc_m1    <= '0;
            sh_last_step <= '0;
            sh_delta     <= '0;
            sh_trace     <= 1'b0;
            cuts         <= '0;
            bias_code    <= '0;
            res_data     <= '0;
            res_step     <= '0;
            res_last     <= 1'b0;
            res_valid    <= 1'b0;
        end else if (abort) begin
            // Also covers start+abort together in IDLE: nothing is latched.
            state     <= S_IDLE;
            res_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sh_cyc_m1    <= (cfg_step_cycles == '0) ? '0 : cfg_step_cycles - CYC_W'(1);
                        sh_last_step <= (cfg_num_steps == '0) ? '0 : cfg_num_steps - STEP_W'(1);
                        sh_delta     <= cfg_bias_delta;
                        sh_trace     <= cfg_trace;
                        cuts         <= cfg_cuts;
                        bias_code    <= cfg_bias_start;
                        step         <= '0;
                        state        <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (tmr_zero) begin
                        state <= S_FREEZE;
                    end
                end
                S_FREEZE: begin
                    if (tmr_zero) begin
                        if (step_emits) begin
                            // Snapshot taken at the edge closing the last freeze cycle.
                            res_data <= state_in;
                            res_step <= step;
                            res_last <= step_final;
                            state    <= S_CAPTURE;
                        end else begin
                            state <= S_ADVANCE;
                        end
                    end
                end
                S_CAPTURE: begin
                    res_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (step_final) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        step      <= step + STEP_W'(1);
                        bias_code <= BIAS_W'(sat_sub(32'(bias_code), 32'(sh_delta)));
                        state     <= S_RUN;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_anneal_scheduler.sv
// tb/tb_anneal_scheduler.sv - self-checking bench for anneal_scheduler
module tb_anneal_scheduler;

    localparam int NS = 144;
    localparam int F  = 2;
    localparam int HS = 8192;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [15:0]    cfg_step_cycles = '0;
    logic [7:0]     cfg_num_steps = '0;
    logic [7:0]     cfg_bias_start = '0;
    logic [7:0]     cfg_bias_delta = '0;
    logic           cfg_trace = 1'b0;
    logic [NS:0]    cfg_cuts = '0;
    logic [NS-1:0]  state_in = '0;
    logic           latch_enable;
    logic [NS:0]    cuts;
    logic [7:0]     bias_code;
    logic [NS-1:0]  res_data;
    logic [7:0]     res_step;
    logic           res_last;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic           busy;
    logic           done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ready_mode = 0;
    logic [NS:0] prev_cuts = '0;

    logic          le_h    [HS];
    logic          busy_h  [HS];
    logic          done_h  [HS];
    logic          valid_h [HS];
    logic          ready_h [HS];
    logic          last_h  [HS];
    logic [7:0]    bias_h  [HS];
    logic [7:0]    step_h  [HS];
    logic [NS-1:0] data_h  [HS];
    logic [NS-1:0] sin_h   [HS];
    logic [NS:0]   cuts_h  [HS];

    anneal_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .cfg_step_cycles (cfg_step_cycles),
        .cfg_num_steps   (cfg_num_steps),
        .cfg_bias_start  (cfg_bias_start),
        .cfg_bias_delta  (cfg_bias_delta),
        .cfg_trace       (cfg_trace),
        .cfg_cuts        (cfg_cuts),
        .state_in        (state_in),
        .latch_enable    (latch_enable),
        .cuts            (cuts),
        .bias_code       (bias_code),
        .res_data        (res_data),
        .res_step        (res_step),
        .res_last        (res_last),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < HS) begin
            le_h[cyc]    <= latch_enable;
            busy_h[cyc]  <= busy;
            done_h[cyc]  <= done;
            valid_h[cyc] <= res_valid;
            ready_h[cyc] <= res_ready;
            last_h[cyc]  <= res_last;
            bias_h[cyc]  <= bias_code;
            step_h[cyc]  <= res_step;
            data_h[cyc]  <= res_data;
            sin_h[cyc]   <= state_in;
            cuts_h[cyc]  <= cuts;
        end
    end

    function automatic logic [159:0] rnd160();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Fresh random chain state every cycle.
    initial begin
        logic [159:0] t;
        forever begin
            @(posedge clk);
            #1;
            t = rnd160();
            state_in = t[NS-1:0];
        end
    end

    // Readout sink: 0 always ready, 1 random, 2 stall 20 cycles per snapshot, 3 never ready.
    initial begin
        int vcnt;
        vcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (res_valid) vcnt++;
            else vcnt = 0;
            case (ready_mode)
                0: res_ready = 1'b1;
                1: res_ready = 1'($urandom_range(0, 1));
                2: res_ready = (vcnt > 20);
                default: res_ready = 1'b0;
            endcase
        end
    end

    function automatic int ix(input int c);
        if (c < 0) return 0;
        if (c >= HS) return HS - 1;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: walks the schedule step by step from the configuration and
    // compares the recorded waveform against the timing rules.
    task automatic check_run(input int t0, input int n_cfg, input int s_cfg, input int b0,
                             input int d, input bit tr, input logic [NS:0] cuts_exp, input int mode);
        int n, s, es, b, last_en, samp, fv, tc, adv, ones, bad, xfers, dones;
        n   = (n_cfg == 0) ? 1 : n_cfg;
        s   = (s_cfg == 0) ? 1 : s_cfg;
        es  = t0 + 1;
        b   = b0;
        adv = es;
        chk("idle_before_start", busy_h[ix(t0)], 1'b0);
        chk("busy_after_start", busy_h[ix(es)], 1'b1);
        chk("cuts_before_start", cuts_h[ix(t0)], prev_cuts);
        for (int k = 0; k < s; k++) begin
            ones = 0;
            for (int c = es; c < es + n; c++) ones += int'(le_h[ix(c)]);
            chk("enable_len", ones, n);
            chk("enable_pre", le_h[ix(es - 1)], 1'b0);
            chk("enable_post", le_h[ix(es + n)], 1'b0);
            chk("bias_step_start", bias_h[ix(es)], b);
            chk("bias_step_end", bias_h[ix(es + n - 1)], b);
            chk("cuts_held", cuts_h[ix(es + n - 1)], cuts_exp);
            last_en = es + n - 1;
            if (tr || k == s - 1) begin
                samp = last_en + F;
                fv = -1;
                tc = -1;
                for (int c = samp + 1; c < samp + 200 && tc < 0; c++) begin
                    if (fv < 0 && valid_h[ix(c)]) fv = c;
                    if (valid_h[ix(c)] && ready_h[ix(c)]) tc = c;
                end
                if (tc < 0) begin
                    chk("transfer_timeout", tc, samp + 2);
                    return;
                end
                chk("res_data", data_h[ix(tc)], sin_h[ix(samp)]);
                chk("res_step", step_h[ix(tc)], k);
                chk("res_last", last_h[ix(tc)], (k == s - 1));
                bad = 0;
                for (int c = fv; c <= tc; c++) begin
                    if (!valid_h[ix(c)] || data_h[ix(c)] !== data_h[ix(tc)] ||
                        step_h[ix(c)] !== step_h[ix(tc)] || last_h[ix(c)] !== last_h[ix(tc)]) bad++;
                end
                chk("res_stable", bad, 0);
                if (mode == 0) chk("step_latency", tc, samp + 2);
                if (mode == 2) chk("backpressure_len", tc - fv, 20);
                adv = tc + 1;
            end else begin
                adv = last_en + F + 1;
            end
            ones = 0;
            for (int c = last_en + 1; c <= adv; c++) ones += int'(le_h[ix(c)]);
            chk("enable_gap", ones, 0);
            if (k < s - 1) begin
                es = adv + 1;
                b  = (b > d) ? b - d : 0;
            end
        end
        chk("done_pulse", done_h[ix(adv + 1)], 1'b1);
        chk("busy_fall", busy_h[ix(adv + 1)], 1'b0);
        xfers = 0;
        dones = 0;
        for (int c = t0; c <= adv + 2; c++) begin
            if (valid_h[ix(c)] && ready_h[ix(c)]) xfers++;
            if (done_h[ix(c)]) dones++;
        end
        chk("snapshot_count", xfers, tr ? s : 1);
        chk("done_count", dones, 1);
    endtask

    task automatic do_run(input int n, input int s, input int b, input int d, input bit tr,
                          input logic [NS:0] cv, input int mode);
        int t0, waited;
        logic [159:0] t;
        ready_mode      = mode;
        cfg_step_cycles = 16'(n);
        cfg_num_steps   = 8'(s);
        cfg_bias_start  = 8'(b);
        cfg_bias_delta  = 8'(d);
        cfg_trace       = tr;
        cfg_cuts        = cv;
        tick();
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        // Configuration changes during the run must be ignored.
        t = rnd160();
        cfg_step_cycles = t[15:0];
        cfg_num_steps   = t[23:16];
        cfg_bias_start  = t[31:24];
        cfg_bias_delta  = t[39:32];
        cfg_trace       = ~tr;
        cfg_cuts        = '1;
        waited = 0;
        while (!done && waited < 4000) begin
            tick();
            waited++;
        end
        if (waited >= 4000) chk("done_timeout", done, 1'b1);
        tick();
        tick();
        check_run(t0, n, s, b, d, tr, cv, mode);
        prev_cuts = cv;
    endtask

    initial begin
        int tr0, t0, t1, w, dones;
        logic [159:0] t;
        logic [NS:0] cv;

        rst = 1'b1;
        repeat (3) tick();
        tr0 = cyc;
        rst = 1'b0;
        tick();
        tick();
        chk("reset_enable", le_h[tr0], 1'b0);
        chk("reset_busy", busy_h[tr0], 1'b0);
        chk("reset_done", done_h[tr0], 1'b0);
        chk("reset_valid", valid_h[tr0], 1'b0);
        chk("reset_cuts", cuts_h[tr0], '0);
        chk("reset_bias", bias_h[tr0], 8'd0);
        chk("reset_data", data_h[tr0], '0);
        chk("reset_step", step_h[tr0], 8'd0);
        chk("reset_last", last_h[tr0], 1'b0);

        // Trace run, saturating final-only run, backpressure, zero config.
        t = rnd160();
        do_run(5, 3, 40, 15, 1'b1, t[NS:0], 0);
        t = rnd160();
        do_run(4, 4, 10, 8, 1'b0, t[NS:0], 0);
        t = rnd160();
        do_run(3, 2, 200, 50, 1'b1, t[NS:0], 2);
        t = rnd160();
        do_run(0, 0, 7, 1, 1'b0, t[NS:0], 0);

        // Abort in the third RUN cycle, with an ignored start while busy.
        ready_mode      = 0;
        t = rnd160();
        cv = t[NS:0];
        cfg_step_cycles = 16'd6;
        cfg_num_steps   = 8'd3;
        cfg_bias_start  = 8'd50;
        cfg_bias_delta  = 8'd5;
        cfg_trace       = 1'b1;
        cfg_cuts        = cv;
        tick();
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        cfg_bias_start = 8'd99;
        cfg_cuts = ~cv;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (8) tick();
        chk("busy_start_ignored_enable", le_h[t0 + 3], 1'b1);
        chk("busy_start_ignored_bias", bias_h[t0 + 3], 8'd50);
        chk("busy_start_ignored_cuts", cuts_h[t0 + 3], cv);
        chk("abort_enable", le_h[t0 + 4], 1'b0);
        chk("abort_valid", valid_h[t0 + 4], 1'b0);
        chk("abort_busy", busy_h[t0 + 4], 1'b0);
        dones = 0;
        for (int c = t0; c <= t0 + 10; c++) if (done_h[c]) dones++;
        chk("abort_no_done", dones, 0);
        chk("abort_idle_stays", busy_h[t0 + 8], 1'b0);
        prev_cuts = cv;

        // Reset while holding a snapshot.
        ready_mode = 3;
        t = rnd160();
        cfg_step_cycles = 16'd2;
        cfg_num_steps   = 8'd2;
        cfg_bias_start  = 8'd30;
        cfg_trace       = 1'b1;
        cfg_cuts        = t[NS:0];
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!res_valid && w < 100) begin
            tick();
            w++;
        end
        chk("hold_reached", res_valid, 1'b1);
        t1 = cyc;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready_mode = 0;
        repeat (4) tick();
        chk("rst_hold_enable", le_h[t1 + 1], 1'b0);
        chk("rst_hold_valid", valid_h[t1 + 1], 1'b0);
        chk("rst_hold_busy", busy_h[t1 + 1], 1'b0);
        chk("rst_hold_cuts", cuts_h[t1 + 1], '0);
        chk("rst_hold_bias", bias_h[t1 + 1], 8'd0);
        dones = 0;
        for (int c = t1; c <= t1 + 3; c++) if (done_h[c]) dones++;
        chk("rst_no_done", dones, 0);
        prev_cuts = '0;

        // Randomized schedules.
        for (int r = 0; r < 10; r++) begin
            t = rnd160();
            do_run(int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 90)),
                   1'($urandom_range(0, 1)), t[NS:0], int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
